grf_wb_arbiter: RTL and testbench

//  Shares the single GRF write port between N write-back requesters (ALU result, load data, link/JAL).

---
 rtl/grf_wb_arbiter_pkg.sv | 14 +
 rtl/grf_wb_arbiter_if.sv | 33 +++
 rtl/grf_wb_arbiter_rr_pick.sv | 36 +++
 rtl/grf_wb_arbiter.sv | 102 ++++++++++
 tb/tb_grf_wb_arbiter.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/grf_wb_arbiter_pkg.sv
// Shared GRF definitions used by the write-back arbiter and its requesters.
package grf_pkg;

    localparam int GRF_AW = 5;
    localparam int GRF_DW = 32;
    localparam logic [GRF_AW-1:0] GRF_ZERO = 5'd0;

    typedef struct packed {
        logic [GRF_AW-1:0] addr;
        logic [GRF_DW-1:0] data;
        logic [GRF_DW-1:0] pc;
    } wb_req_t;

endpackage

// File: rtl/grf_wb_arbiter_if.sv
// Write-back bus between the requesters/decode (master) and the GRF arbiter (slave).
interface grf_wb_arbiter_if
    import grf_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int AW    = GRF_AW,
    parameter int DW    = GRF_DW
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*AW-1:0] req_addr;
    logic [N_REQ*DW-1:0] req_data;
    logic [N_REQ*DW-1:0] req_pc;
    logic [N_REQ-1:0]    req_ready;
    logic                wb_hold;
    logic                WE;
    logic [AW-1:0]       A3;
    logic [DW-1:0]       WD;
    logic [DW-1:0]       PC;
    logic [AW-1:0]       q_a1;
    logic [AW-1:0]       q_a2;
    logic                q_hit1;
    logic                q_hit2;

    modport master (
        output req_valid, req_addr, req_data, req_pc, wb_hold, q_a1, q_a2,
        input  req_ready, WE, A3, WD, PC, q_hit1, q_hit2
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_pc, wb_hold, q_a1, q_a2,
        output req_ready, WE, A3, WD, PC, q_hit1, q_hit2
    );
endinterface

// File: rtl/grf_wb_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate by the pointer, take the lowest set bit, rotate back.
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic [2*N-1:0] doubled;
    logic [N-1:0]   rotated;
    logic [IW-1:0]  off;
    logic [IW:0]    sum;

    // NOTE: every always_comb output gets a default before any branch, otherwise a latch is inferred.
    always_comb begin
        doubled = {req, req};
        rotated = N'(doubled >> ptr);
        any     = 1'b0;
        off     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                any = 1'b1;
                off = IW'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (IW+1)'(N)) begin
            sum = sum - (IW+1)'(N);
        end
        idx   = sum[IW-1:0];
        grant = any ? ({{(N-1){1'b0}}, 1'b1} << idx) : '0;
    end
endmodule

// File: rtl/grf_wb_arbiter.sv
// Round-robin arbiter sharing the GRF write port, with a registered output stage and pending-write query.
// Define GRF_WB_TRACE_EN to print a GRF write trace in simulation.
module grf_wb_arbiter
    import grf_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int AW    = GRF_AW,
    parameter int DW    = GRF_DW
) (
    input logic              Clk,
    input logic              Reset,
    grf_wb_arbiter_if.slave  bus
);
    localparam int IW = $clog2(N_REQ);

    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    win_idx;
    logic [IW-1:0]    next_ptr;
    logic [N_REQ-1:0] grant;
    logic             any;
    logic [AW-1:0]    win_addr;
    logic [DW-1:0]    win_data;
    logic [DW-1:0]    win_pc;

    logic             we_q;
    logic             out_valid;
    logic [AW-1:0]    a3_q;
    logic [DW-1:0]    wd_q;
    logic [DW-1:0]    pc_q;

    logic             req_hit1;
    logic             req_hit2;

    rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (win_idx),
        .any   (any)
    );

    assign win_addr = bus.req_addr[int'(win_idx)*AW +: AW];
    assign win_data = bus.req_data[int'(win_idx)*DW +: DW];
    assign win_pc   = bus.req_pc[int'(win_idx)*DW +: DW];
    assign next_ptr = (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

    // Requests are invisible while reset is asserted, so no grant leaks out during reset.
    assign bus.req_ready = (Reset && !bus.wb_hold) ? grant : '0;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            we_q      <= 1'b0;
            out_valid <= 1'b0;
            a3_q      <= '0;
            wd_q      <= '0;
            pc_q      <= '0;
            rr_ptr    <= '0;
        end else if (bus.wb_hold) begin
            we_q <= 1'b0;
        end else if (any) begin
            we_q      <= (win_addr != '0);
            out_valid <= 1'b1;
            a3_q      <= win_addr;
            wd_q      <= win_data;
            pc_q      <= win_pc;
            rr_ptr    <= next_ptr;
        end else begin
            we_q      <= 1'b0;
            out_valid <= 1'b0;
        end
    end

    assign bus.WE = we_q;
    assign bus.A3 = a3_q;
    assign bus.WD = wd_q;
    assign bus.PC = pc_q;

    // A consumed $0 write leaves out_valid set with a3_q=0; the q != 0 guard keeps it from hitting.
    always_comb begin
        req_hit1 = 1'b0;
        req_hit2 = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (Reset && bus.req_valid[i]) begin
                if (bus.req_addr[i*AW +: AW] == bus.q_a1) req_hit1 = 1'b1;
                if (bus.req_addr[i*AW +: AW] == bus.q_a2) req_hit2 = 1'b1;
            end
        end
        bus.q_hit1 = (bus.q_a1 != '0) && (req_hit1 || (out_valid && a3_q == bus.q_a1));
        bus.q_hit2 = (bus.q_a2 != '0) && (req_hit2 || (out_valid && a3_q == bus.q_a2));
    end

`ifdef GRF_WB_TRACE_EN
    always @(posedge Clk) begin
        if (Reset && !bus.wb_hold && any) begin
            if (win_addr != '0) $display("@%h: $%d <= %h", win_pc, win_addr, win_data);
            else                $display("@%h: drop $0", win_pc);
        end
    end
`else
`endif
endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed self-checking bench for grf_wb_arbiter with hand-computed expectations.
module tb_grf_wb_arbiter;
    import grf_pkg::*;

    localparam int N_REQ = 3;
    localparam int AW    = GRF_AW;
    localparam int DW    = GRF_DW;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    grf_wb_arbiter_if #(.N_REQ(N_REQ), .AW(AW), .DW(DW)) bus ();

    grf_wb_arbiter #(.N_REQ(N_REQ), .AW(AW), .DW(DW)) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input wb_req_t r);
        bus.req_valid[i]         = v;
        bus.req_addr[i*AW +: AW] = r.addr;
        bus.req_data[i*DW +: DW] = r.data;
        bus.req_pc[i*DW +: DW]   = r.pc;
    endtask

    task automatic drop(input int i);
        bus.req_valid[i] = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.req_pc    = '0;
        bus.wb_hold   = 1'b0;
        bus.q_a1      = '0;
        bus.q_a2      = '0;

        // Reset state; a request raised during reset must not be granted
        set_req(0, 1'b1, '{addr: 5'd4, data: 32'hAAAA, pc: 32'h10});
        #2;
        check("rst_we",    32'(bus.WE), 32'd0);
        check("rst_a3",    32'(bus.A3), 32'd0);
        check("rst_wd",    bus.WD, 32'd0);
        check("rst_pc",    bus.PC, 32'd0);
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        drop(0);
        #8 rst_n = 1'b1;

        // Single requester: grant same cycle, write next cycle
        set_req(0, 1'b1, '{addr: 5'd5, data: 32'h1234, pc: 32'h3000});
        #1;
        check("single_ready", 32'(bus.req_ready), 32'b001);
        step();
        drop(0);
        check("single_we", 32'(bus.WE), 32'd1);
        check("single_a3", 32'(bus.A3), 32'd5);
        check("single_wd", bus.WD, 32'h1234);
        check("single_pc", bus.PC, 32'h3000);

        // Asynchronous reset mid-stream while WE=1, with a request pending
        set_req(0, 1'b1, '{addr: 5'd6, data: 32'h5678, pc: 32'h3004});
        rst_n = 1'b0;
        #1;
        check("mid_rst_we",    32'(bus.WE), 32'd0);
        check("mid_rst_a3",    32'(bus.A3), 32'd0);
        check("mid_rst_ready", 32'(bus.req_ready), 32'd0);
        drop(0);
        #2 rst_n = 1'b1;

        // All three valid and held from rr_ptr=0: 001, 010, 100, 001
        set_req(0, 1'b1, '{addr: 5'd1, data: 32'hA0, pc: 32'h100});
        set_req(1, 1'b1, '{addr: 5'd2, data: 32'hA1, pc: 32'h104});
        set_req(2, 1'b1, '{addr: 5'd3, data: 32'hA2, pc: 32'h108});
        #1;
        check("rr_ready0", 32'(bus.req_ready), 32'b001);
        step();
        check("rr_a3_0",   32'(bus.A3), 32'd1);
        check("rr_ready1", 32'(bus.req_ready), 32'b010);
        step();
        check("rr_a3_1",   32'(bus.A3), 32'd2);
        check("rr_wd_1",   bus.WD, 32'hA1);
        check("rr_ready2", 32'(bus.req_ready), 32'b100);
        step();
        check("rr_a3_2",   32'(bus.A3), 32'd3);
        check("rr_ready3", 32'(bus.req_ready), 32'b001);
        step();
        check("rr_a3_3",   32'(bus.A3), 32'd1);
        check("rr_we_3",   32'(bus.WE), 32'd1);
        drop(0); drop(1); drop(2);
        step();
        check("idle_we", 32'(bus.WE), 32'd0);
        check("idle_a3", 32'(bus.A3), 32'd1);
        check("idle_wd", bus.WD, 32'hA0);

        // Write to $0 is consumed but not performed (rr_ptr=1)
        set_req(1, 1'b1, '{addr: 5'd0, data: 32'hFFFF, pc: 32'h200});
        #1;
        check("zero_ready", 32'(bus.req_ready), 32'b010);
        step();
        drop(1);
        check("zero_we", 32'(bus.WE), 32'd0);

        // Hold for three cycles with req2 pending (rr_ptr=2)
        set_req(2, 1'b1, '{addr: 5'd9, data: 32'h5555, pc: 32'h300});
        bus.wb_hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("hold_ready", 32'(bus.req_ready), 32'd0);
            step();
            check("hold_we", 32'(bus.WE), 32'd0);
        end
        bus.wb_hold = 1'b0;
        #1;
        check("unhold_ready", 32'(bus.req_ready), 32'b100);
        step();
        drop(2);
        check("unhold_we", 32'(bus.WE), 32'd1);
        check("unhold_a3", 32'(bus.A3), 32'd9);
        check("unhold_wd", bus.WD, 32'h5555);

        // Hold applied while WE=1: WE drops, output stage (and out_valid) kept
        bus.wb_hold = 1'b1;
        bus.q_a2    = 5'd9;
        #1;
        check("hold_hit2_pre", 32'(bus.q_hit2), 32'd1);
        step();
        check("hold_we_drop", 32'(bus.WE), 32'd0);
        check("hold_a3_keep", 32'(bus.A3), 32'd9);
        check("hold_hit2",    32'(bus.q_hit2), 32'd1);
        bus.wb_hold = 1'b0;
        step();
        check("release_hit2", 32'(bus.q_hit2), 32'd0);

        // Pending-write query (rr_ptr=0)
        bus.q_a1 = 5'd7;
        bus.q_a2 = 5'd0;
        set_req(1, 1'b1, '{addr: 5'd7, data: 32'h77, pc: 32'h400});
        #1;
        check("q_hit1_req",   32'(bus.q_hit1), 32'd1);
        check("q_hit2_zero",  32'(bus.q_hit2), 32'd0);
        check("q_ready",      32'(bus.req_ready), 32'b010);
        step();
        drop(1);
        #1;
        check("q_hit1_stage", 32'(bus.q_hit1), 32'd1);
        check("q_a3",         32'(bus.A3), 32'd7);
        step();
        check("q_hit1_gone",  32'(bus.q_hit1), 32'd0);
        bus.q_a1 = 5'd0;

        // Pointer wrap: grant req2 (ptr 2 -> 0), then req0 beats req2
        set_req(2, 1'b1, '{addr: 5'd10, data: 32'hB2, pc: 32'h500});
        #1;
        check("wrap_ready2", 32'(bus.req_ready), 32'b100);
        step();
        set_req(0, 1'b1, '{addr: 5'd11, data: 32'hB0, pc: 32'h504});
        #1;
        check("wrap_ready0", 32'(bus.req_ready), 32'b001);
        step();
        drop(0); drop(2);
        check("wrap_a3", 32'(bus.A3), 32'd11);
        check("wrap_pc", bus.PC, 32'h504);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
